// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator: phase accumulator with a signed
// phase offset, followed by a two-stage pipeline that shapes the phase into a
// sine (quarter-wave table), triangle, square or sawtooth sample.
`timescale 1ns/1ps

module dds_wave_gen #(
  parameter int unsigned OUT_W   = 8,   // output sample width
  parameter int unsigned ACC_W   = 16,  // phase accumulator width
  parameter int unsigned LUT_AW  = 5,   // quarter-wave table address width
  parameter int unsigned PHASE_W = 9    // signed phase-offset width
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      sync,
  input  logic [ACC_W-1:0]          freq_word,
  input  logic signed [PHASE_W-1:0] phase_offset,
  input  logic [1:0]                mode,
  output logic [OUT_W-1:0]          wave_out,
  output logic                      out_valid,
  output logic                      cycle_start
);

  // Legal parameter space: ACC_W >= LUT_AW+2, ACC_W >= OUT_W+1, ACC_W >= PHASE_W.
  localparam int unsigned OFF_SH = ACC_W - PHASE_W;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);

  typedef enum logic [1:0] {
    MODE_SINE   = 2'b00,
    MODE_TRI    = 2'b01,
    MODE_SQUARE = 2'b10,
    MODE_SAW    = 2'b11
  } mode_e;

  // Quarter-wave sine table: round(127 * sin(pi*k/64)), k = 0..31.
  // Values correspond to OUT_W = 8, LUT_AW = 5.
  localparam logic [7:0] SINE_Q [0:31] = '{
    8'd0,   8'd6,   8'd12,  8'd19,  8'd25,  8'd31,  8'd37,  8'd43,
    8'd49,  8'd54,  8'd60,  8'd65,  8'd71,  8'd76,  8'd81,  8'd85,
    8'd90,  8'd94,  8'd98,  8'd102, 8'd106, 8'd109, 8'd112, 8'd115,
    8'd117, 8'd120, 8'd122, 8'd123, 8'd125, 8'd126, 8'd126, 8'd127
  };

  logic [ACC_W-1:0] acc;
  logic             start_pend;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] off_ext;
  logic [ACC_W-1:0] phase;
  logic             issue;

  logic [ACC_W-1:0] s1_phase;
  mode_e            s1_mode;
  logic             s1_valid;
  logic             s1_start;

  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  logic [LUT_AW-1:0] lut_idx;
  logic [OUT_W-1:0]  lut_val;
  logic [OUT_W:0]    tri_t;
  logic [OUT_W-1:0]  wave_c;
  logic              phase_unused;

  // The carry bit of the accumulator update marks a period wrap.
  assign acc_sum = {1'b0, acc} + {1'b0, freq_word};
  // Sign-extend the offset and align it with the accumulator MSBs.
  assign off_ext = ACC_W'(phase_offset) << OFF_SH;
  assign phase   = acc + off_ext;
  assign issue   = enable & ~sync;

  // Phase accumulator and pending period-start flag; sync wins over enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      start_pend <= 1'b1;
    end else if (sync) begin
      acc        <= '0;
      start_pend <= 1'b1;
    end else if (enable) begin
      acc        <= acc_sum[ACC_W-1:0];
      start_pend <= acc_sum[ACC_W];
    end
  end

  // Stage 1: capture effective phase, mode and start flag of the issued sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_phase <= '0;
      s1_mode  <= MODE_SINE;
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_phase <= phase;
        s1_mode  <= mode_e'(mode);
        s1_start <= start_pend;
      end
    end
  end

  // Waveform shaping from the stage-1 phase.
  always_comb begin
    quad    = s1_phase[ACC_W-1 -: 2];
    idx     = s1_phase[ACC_W-3 -: LUT_AW];
    lut_idx = quad[0] ? ~idx : idx;
    lut_val = OUT_W'(SINE_Q[lut_idx]);
    tri_t   = s1_phase[ACC_W-1 -: OUT_W+1];
    wave_c  = MID;
    case (s1_mode)
      MODE_SINE:   wave_c = quad[1] ? (MID - lut_val) : (MID + lut_val);
      MODE_TRI:    wave_c = tri_t[OUT_W] ? ~tri_t[OUT_W-1:0] : tri_t[OUT_W-1:0];
      MODE_SQUARE: wave_c = s1_phase[ACC_W-1] ? '0 : '1;
      MODE_SAW:    wave_c = s1_phase[ACC_W-1 -: OUT_W];
      default:     wave_c = MID;
    endcase
  end

  // Low phase bits only matter for finer tables; keep them visibly consumed.
  assign phase_unused = ^s1_phase;

  // Stage 2: registered outputs; wave_out holds while no sample is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wave_out    <= MID;
      out_valid   <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      out_valid   <= s1_valid;
      cycle_start <= s1_valid & s1_start;
      if (s1_valid) begin
        wave_out <= wave_c;
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed vector table plus
// hand-written sequences for latency, sync, enable hold and async reset.
`timescale 1ns/1ps

module tb_dds_wave_gen;

  logic              clock;
  logic              reset_n;
  logic              enable;
  logic              sync;
  logic [15:0]       freq_word;
  logic signed [8:0] phase_offset;
  logic [1:0]        mode;
  logic [7:0]        wave_out;
  logic              out_valid;
  logic              cycle_start;

  int n_tests;
  int n_fail;

  logic [7:0] cap_wave  [0:63];
  logic       cap_start [0:63];

  typedef struct {
    logic [15:0] fw;
    int          off;
    logic [1:0]  md;
    int          idx;
    int          wave;
    int          start;
  } vec_t;

  vec_t vecs[$];

  dds_wave_gen dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .sync         (sync),
    .freq_word    (freq_word),
    .phase_offset (phase_offset),
    .mode         (mode),
    .wave_out     (wave_out),
    .out_valid    (out_valid),
    .cycle_start  (cycle_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] fw, input int off, input logic [1:0] md,
                         input int idx, input int wave, input int start);
    vec_t v;
    v.fw = fw; v.off = off; v.md = md; v.idx = idx; v.wave = wave; v.start = start;
    vecs.push_back(v);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    enable  = 1'b0;
    sync    = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Reset, start a run and record the first n issued samples.
  task automatic capture(input logic [15:0] fw, input int off, input logic [1:0] md,
                         input int n, output int got);
    apply_reset();
    freq_word    = fw;
    phase_offset = 9'(off);
    mode         = md;
    enable       = 1'b1;
    got          = 0;
    for (int c = 0; c < 4 * n + 16 && got < n; c++) begin
      @(negedge clock);
      if (out_valid) begin
        cap_wave[got]  = wave_out;
        cap_start[got] = cycle_start;
        got++;
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    int got;
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b1;
    enable       = 1'b0;
    sync         = 1'b0;
    freq_word    = '0;
    phase_offset = '0;
    mode         = 2'b00;

    // fw, offset, mode, sample index, expected wave, expected cycle_start
    add_vec(16'h0800,    0, 2'b00,  0, 128, 1);
    add_vec(16'h0800,    0, 2'b00,  4, 218, 0);
    add_vec(16'h0800,    0, 2'b00,  8, 255, 0);
    add_vec(16'h0800,    0, 2'b00, 10, 243, 0);
    add_vec(16'h0800,    0, 2'b00, 16, 128, 0);
    add_vec(16'h0800,    0, 2'b00, 20,  38, 0);
    add_vec(16'h0800,    0, 2'b00, 24,   1, 0);
    add_vec(16'h0800,    0, 2'b00, 32, 128, 1);
    add_vec(16'h0800,   64, 2'b00,  0, 218, 1);
    add_vec(16'h0000,  128, 2'b00,  0, 255, 1);
    add_vec(16'h0000,  128, 2'b00,  5, 255, 0);
    add_vec(16'h0000, -128, 2'b00,  0,   1, 1);
    add_vec(16'h0000, -128, 2'b00,  3,   1, 0);
    add_vec(16'h0000, -256, 2'b00,  0, 128, 1);
    add_vec(16'h0000, -256, 2'b00,  3, 128, 0);
    add_vec(16'h0800,    0, 2'b11,  0,   0, 1);
    add_vec(16'h0800,    0, 2'b11,  5,  40, 0);
    add_vec(16'h0800,    0, 2'b11, 31, 248, 0);
    add_vec(16'h0800,    0, 2'b11, 32,   0, 1);
    add_vec(16'h0800,    0, 2'b10,  0, 255, 1);
    add_vec(16'h0800,    0, 2'b10, 15, 255, 0);
    add_vec(16'h0800,    0, 2'b10, 16,   0, 0);
    add_vec(16'h0800,    0, 2'b10, 31,   0, 0);
    add_vec(16'h0800,    0, 2'b01,  0,   0, 1);
    add_vec(16'h0800,    0, 2'b01,  8, 128, 0);
    add_vec(16'h0800,    0, 2'b01, 15, 240, 0);
    add_vec(16'h0800,    0, 2'b01, 16, 255, 0);
    add_vec(16'h0800,    0, 2'b01, 24, 127, 0);

    // Reset state and first-sample latency.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("reset wave_out", int'(wave_out), 128);
    check("reset out_valid", int'(out_valid), 0);
    check("reset cycle_start", int'(cycle_start), 0);
    repeat (2) @(negedge clock);
    reset_n      = 1'b1;
    freq_word    = 16'h0800;
    phase_offset = '0;
    mode         = 2'b00;
    enable       = 1'b1;
    @(negedge clock);
    check("latency edge1 out_valid", int'(out_valid), 0);
    @(negedge clock);
    check("latency edge2 out_valid", int'(out_valid), 1);
    check("first sample wave", int'(wave_out), 128);
    check("first sample start", int'(cycle_start), 1);
    @(negedge clock);
    check("sample1 wave", int'(wave_out), 153);
    check("sample1 start", int'(cycle_start), 0);

    // Sync while running.
    repeat (8) @(negedge clock);
    check("sample9 wave", int'(wave_out), 251);
    sync = 1'b1;
    @(negedge clock);
    check("sample10 valid", int'(out_valid), 1);
    check("sample10 wave", int'(wave_out), 243);
    sync = 1'b0;
    @(negedge clock);
    check("sync gap valid", int'(out_valid), 0);
    @(negedge clock);
    check("post-sync valid", int'(out_valid), 1);
    check("post-sync wave", int'(wave_out), 128);
    check("post-sync start", int'(cycle_start), 1);

    // Enable low for five cycles: drain, hold, then resume from held phase.
    enable = 1'b0;
    @(negedge clock);
    check("drain valid", int'(out_valid), 1);
    check("drain wave", int'(wave_out), 153);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("hold%0d valid", k), int'(out_valid), 0);
      check($sformatf("hold%0d wave", k), int'(wave_out), 153);
    end
    enable = 1'b1;
    @(negedge clock);
    check("resume fill valid", int'(out_valid), 0);
    @(negedge clock);
    check("resume valid", int'(out_valid), 1);
    check("resume wave", int'(wave_out), 177);
    check("resume start", int'(cycle_start), 0);

    // Asynchronous reset between edges.
    repeat (3) @(negedge clock);
    check("pre-reset wave", int'(wave_out), 234);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset wave", int'(wave_out), 128);
    check("async reset valid", int'(out_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("after reset fill valid", int'(out_valid), 0);
    @(negedge clock);
    check("after reset valid", int'(out_valid), 1);
    check("after reset wave", int'(wave_out), 128);
    check("after reset start", int'(cycle_start), 1);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      capture(vecs[i].fw, vecs[i].off, vecs[i].md, vecs[i].idx + 1, got);
      if (got <= vecs[i].idx) begin
        check($sformatf("vec%0d sample count", i), got, vecs[i].idx + 1);
      end else begin
        check($sformatf("vec%0d wave", i), int'(cap_wave[vecs[i].idx]), vecs[i].wave);
        check($sformatf("vec%0d start", i), int'(cap_start[vecs[i].idx]), vecs[i].start);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
